gmii_tx_sched: RTL
==================

// Module: gmii_tx_sched
// PURPOSE
//  Packet scheduler in front of the GMII transmitter. Arbitrates one Ethernet frame at a time
//  between buffered video lines and queued audio (AUX) entries. Chooses VIDEO, AUDIO or VIDAX
//  (video + piggybacked audio), the AUX entry count and the IP/UDP lengths, then waits for
//  frame completion and an inter-frame gap. Runs entirely in the tx_clk domain.
// PARAMETERS
//  AUDIOMAX     20     max AUX entries per frame (1..31)
//  AUXSIZE      34     bytes per AUX entry
//  VID_IP_LEN   1231   IP total length of a video-only frame
//  VID_UDP_LEN  1211   UDP length of a video-only frame
//  AUD_IP_LEN   43     IP length base for audio-only frames
//  AUD_UDP_LEN  9      UDP length base for audio-only frames
//  AUD_THRESH   8      min aud_level for an audio-only frame without starvation
//  AUD_TIMEOUT  4096   cycles of pending audio before forced audio-only frame
//  DONE_TMO     4095   max cycles in BUSY without tx_done
//  GAP_CYC      12     idle cycles after tx_done before the next decision
// PORTS
//  tx_clk      in   1   clock; sole clock domain
//  sys_rst     in   1   synchronous, active-high reset
//  en          in   1   scheduler enable; low = no new grants
//  vid_rdy     in   1   one full video line buffered, FIFO non-empty
//  aud_level   in   5   AUX FIFO entries available (saturating at 31)
//  tx_done     in   1   one-cycle pulse: transmitter finished the FCS of the granted frame
//  grant       out  1   one-cycle pulse: start a frame with the fields below
//  pkt_type    out  8   0x00 VIDEO, 0x01 AUDIO, 0x02 VIDAX; held from grant to tx_done
//  grant_ade   out  5   AUX entries in the frame (0 for VIDEO); held
//  ip_length   out  16  IP total length; held
//  udp_length  out  16  UDP length; held
//  busy        out  1   high from grant through the end of GAP
//  err_tmo     out  1   sticky; set on DONE_TMO expiry, cleared only by sys_rst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, age/timeout/gap counters 0. Reset mid-frame aborts at once.
//  States: IDLE -> GRANT -> BUSY -> GAP -> IDLE.
//  IDLE: with en=1, evaluate in priority order each cycle on sampled inputs:
//   1. aud_level!=0 && age>=AUD_TIMEOUT -> AUDIO, n=min(aud_level,AUDIOMAX)
//   2. vid_rdy -> VIDEO if aud_level==0, else VIDAX with n=min(aud_level,AUDIOMAX)
//   3. aud_level>=AUD_THRESH -> AUDIO, n=min(aud_level,AUDIOMAX)
//   4. otherwise stay in IDLE.
//   On a decision, register pkt_type, grant_ade and lengths, then go to GRANT.
//  GRANT: grant=1 for exactly this cycle, busy=1, go to BUSY. Latency: decision cycle + 1.
//  Lengths (16-bit, no overflow since AUXSIZE*31<2^16):
//   VIDEO VID_*_LEN; VIDAX VID_*_LEN+AUXSIZE*n; AUDIO AUD_*_LEN+AUXSIZE*n.
//  BUSY: hold all fields. tx_done -> GAP. DONE_TMO cycles without tx_done -> set err_tmo, go to GAP.
//  GAP: count GAP_CYC cycles, then IDLE. busy drops on the IDLE entry cycle.
//  age counter: increments while aud_level!=0 and no frame with n>0 has been granted;
//   clears on a GRANT with n>0 or when aud_level==0; saturates at AUD_TIMEOUT.
//  Edge cases:
//   - tx_done outside BUSY is ignored.
//   - tx_done in the GRANT cycle is ignored.
//   - en falling in BUSY/GAP: current frame completes and no new decision is made.
//   - Changes to vid_rdy or aud_level after the decision do not alter the held fields.
//   - aud_level>AUDIOMAX: clamp to AUDIOMAX; the remainder waits for the next frame.
// STRUCTURE
//  Package gmii_pkt_pkg holds: PKT_VIDEO/PKT_AUDIO/PKT_VIDAX codes, AUXSIZE, the length bases,
//  and the scheduler state enum. The transmitter imports the same constants.
//  Sub-module gmii_len_calc (combinational: type, n -> ip_length, udp_length) is the only split.
//  Everything else is a single FSM with the age, timeout and gap counters.
// TESTING
//  1. vid_rdy=1, aud_level=0 -> grant 1 cycle later; VIDEO, ade=0, ip=1231, udp=1211.
//  2. vid_rdy=1, aud_level=25 -> VIDAX, ade=20, ip=1911, udp=1891; fields held until tx_done.
//  3. vid_rdy=0, aud_level=8 -> AUDIO, ade=8, ip=315, udp=281.
//     With aud_level=3: no grant until age hits 4096, then AUDIO with ade=3.
//  4. Grant issued, tx_done withheld 4095 cycles -> err_tmo=1, GAP, IDLE.
//     tx_done in IDLE -> no effect.
//  5. tx_done, then vid_rdy=1 -> next grant no earlier than GAP_CYC+2 cycles after tx_done.
//     en=0 during BUSY -> no further grant.
//  6. sys_rst asserted in BUSY -> next cycle: all outputs 0, state IDLE, err_tmo cleared.

Source files
------------

// File: rtl/gmii_pkt_pkg.sv
// Shared packet codes, length bases and scheduler state encoding for the
// GMII transmit path (scheduler and transmitter).
package gmii_pkt_pkg;

    localparam logic [7:0] PKT_VIDEO = 8'h00;
    localparam logic [7:0] PKT_AUDIO = 8'h01;
    localparam logic [7:0] PKT_VIDAX = 8'h02;

    localparam int AUXSIZE     = 34;
    localparam int VID_IP_LEN  = 1231;
    localparam int VID_UDP_LEN = 1211;
    localparam int AUD_IP_LEN  = 43;
    localparam int AUD_UDP_LEN = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gmii_len_calc.sv
// IP/UDP length calculation for a scheduled frame from its type and
// AUX entry count.
module gmii_len_calc
    import gmii_pkt_pkg::*;
#(
    parameter int AUX_BYTES = AUXSIZE,
    parameter int VID_IP    = VID_IP_LEN,
    parameter int VID_UDP   = VID_UDP_LEN,
    parameter int AUD_IP    = AUD_IP_LEN,
    parameter int AUD_UDP   = AUD_UDP_LEN
) (
    input  logic [7:0]  pkt_type,
    input  logic [4:0]  n,
    output logic [15:0] ip_length,
    output logic [15:0] udp_length
);

    logic [15:0] aux_bytes;

    // 31 entries of AUX_BYTES always fits in 16 bits
    assign aux_bytes = 16'(AUX_BYTES * int'(n));

    always_comb begin
        ip_length  = 16'd0;
        udp_length = 16'd0;
        case (pkt_type)
            PKT_VIDEO: begin
                ip_length  = 16'(VID_IP);
                udp_length = 16'(VID_UDP);
            end
            PKT_VIDAX: begin
                ip_length  = 16'(VID_IP) + aux_bytes;
                udp_length = 16'(VID_UDP) + aux_bytes;
            end
            PKT_AUDIO: begin
                ip_length  = 16'(AUD_IP) + aux_bytes;
                udp_length = 16'(AUD_UDP) + aux_bytes;
            end
            default: begin
                ip_length  = 16'd0;
                udp_length = 16'd0;
            end
        endcase
    end

endmodule

// File: rtl/gmii_tx_sched.sv
// Frame scheduler ahead of the GMII transmitter: picks VIDEO, AUDIO or
// VIDAX per frame, then waits for completion and the inter-frame gap.
module gmii_tx_sched
    import gmii_pkt_pkg::*;
#(
    parameter int AUDIOMAX    = 20,
    parameter int AUX_BYTES   = AUXSIZE,
    parameter int VID_IP      = VID_IP_LEN,
    parameter int VID_UDP     = VID_UDP_LEN,
    parameter int AUD_IP      = AUD_IP_LEN,
    parameter int AUD_UDP     = AUD_UDP_LEN,
    parameter int AUD_THRESH  = 8,
    parameter int AUD_TIMEOUT = 4096,
    parameter int DONE_TMO    = 4095,
    parameter int GAP_CYC     = 12
) (
    input  logic        tx_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        vid_rdy,
    input  logic [4:0]  aud_level,
    input  logic        tx_done,
    output logic        grant,
    output logic [7:0]  pkt_type,
    output logic [4:0]  grant_ade,
    output logic [15:0] ip_length,
    output logic [15:0] udp_length,
    output logic        busy,
    output logic        err_tmo
);

    localparam int AGE_W = $clog2(AUD_TIMEOUT + 1);
    localparam int TMO_W = $clog2(DONE_TMO + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [4:0]       AMAX  = 5'(AUDIOMAX);
    localparam logic [4:0]       THR   = 5'(AUD_THRESH);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AUD_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    sched_state_t     state;
    logic [AGE_W-1:0] age;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic        dec_hit;
    logic [7:0]  dec_type;
    logic [4:0]  dec_n;
    logic [4:0]  n_clamp;
    logic        aud_stale;
    logic [15:0] dec_ip;
    logic [15:0] dec_udp;

    assign n_clamp   = (aud_level > AMAX) ? AMAX : aud_level;
    assign aud_stale = (aud_level != 5'd0) && (age >= AGE_MAX);

    // Starved audio beats video; video carries any pending audio along
    always_comb begin
        dec_hit  = 1'b0;
        dec_type = PKT_VIDEO;
        dec_n    = 5'd0;
        if (aud_stale) begin
            dec_hit  = 1'b1;
            dec_type = PKT_AUDIO;
            dec_n    = n_clamp;
        end else if (vid_rdy) begin
            dec_hit  = 1'b1;
            dec_type = (aud_level == 5'd0) ? PKT_VIDEO : PKT_VIDAX;
            dec_n    = n_clamp;
        end else if (aud_level >= THR) begin
            dec_hit  = 1'b1;
            dec_type = PKT_AUDIO;
            dec_n    = n_clamp;
        end
    end

    gmii_len_calc #(
        .AUX_BYTES (AUX_BYTES),
        .VID_IP    (VID_IP),
        .VID_UDP   (VID_UDP),
        .AUD_IP    (AUD_IP),
        .AUD_UDP   (AUD_UDP)
    ) u_len (
        .pkt_type   (dec_type),
        .n          (dec_n),
        .ip_length  (dec_ip),
        .udp_length (dec_udp)
    );

    always_ff @(posedge tx_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            pkt_type   <= 8'd0;
            grant_ade  <= 5'd0;
            ip_length  <= 16'd0;
            udp_length <= 16'd0;
            err_tmo    <= 1'b0;
            age        <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            if ((state == ST_GRANT && grant_ade != 5'd0) ||
                aud_level == 5'd0) begin
                age <= '0;
            end else if (age < AGE_MAX) begin
                age <= age + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (en && dec_hit) begin
                        pkt_type   <= dec_type;
                        grant_ade  <= dec_n;
                        ip_length  <= dec_ip;
                        udp_length <= dec_udp;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    tmo_cnt <= '0;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (tx_done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_tmo <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign grant = (state == ST_GRANT);
    assign busy  = (state != ST_IDLE);

endmodule
